// File: rtl/word_byte_serializer.sv
// Serializes one NBYTES x BYTE_W word per handshake into a valid/ready byte stream.
// Back-to-back words load on the final-byte beat, so the stream has no bubbles.
module word_byte_serializer #(
    parameter int NBYTES    = 7,
    parameter int BYTE_W    = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NBYTES*BYTE_W-1:0]    in_word,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [BYTE_W-1:0]           out_byte,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [$clog2(NBYTES)-1:0]   byte_idx,
    output logic                        busy
);
    localparam int WW = NBYTES * BYTE_W;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t              state_q;
    logic [WW-1:0]       sr_q;
    logic [WW-1:0]       sr_d;
    logic [IW-1:0]       idx_q;
    logic [IW-1:0]       idx_d;
    logic [BYTE_W-1:0]   byte_q;
    logic                valid_q;
    logic                last_q;
    logic                accept;
    logic                beat;

    // The byte on the output end of the shift register is always the next one to send.
    function automatic logic [BYTE_W-1:0] head(input logic [WW-1:0] w);
        if (LSB_FIRST) return w[BYTE_W-1:0];
        else           return w[WW-1 -: BYTE_W];
    endfunction

    always_comb begin
        in_ready = !rst && ((state_q == IDLE) || (out_ready && last_q));
        accept   = in_valid && in_ready;
        beat     = valid_q && out_ready;
        idx_d    = idx_q + 1'b1;
        sr_d     = LSB_FIRST ? (sr_q >> BYTE_W) : (sr_q << BYTE_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (accept) begin
            // Covers both a load from IDLE and a reload on the final beat.
            state_q <= SHIFT;
            sr_q    <= in_word;
            idx_q   <= '0;
            byte_q  <= head(in_word);
            valid_q <= 1'b1;
            last_q  <= 1'b0;
        end else if (beat) begin
            if (last_q) begin
                state_q <= IDLE;
                sr_q    <= '0;
                idx_q   <= '0;
                byte_q  <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                sr_q    <= sr_d;
                idx_q   <= idx_d;
                byte_q  <= head(sr_d);
                last_q  <= (idx_d == LAST_IDX);
            end
        end
    end

    assign out_byte  = byte_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign byte_idx  = idx_q;
    assign busy      = (state_q == SHIFT);
endmodule

// File: tb/tb_word_byte_serializer.sv
// Directed bench for word_byte_serializer: LSB-first and MSB-first instances share stimulus.
module tb_word_byte_serializer;
    logic        clk = 1'b0;
    logic        rst;
    logic [55:0] in_word;
    logic        in_valid;
    logic        out_ready;
    logic        in_ready,  in_ready_m;
    logic [7:0]  out_byte,  out_byte_m;
    logic        out_valid, out_valid_m;
    logic        out_last,  out_last_m;
    logic [2:0]  byte_idx,  byte_idx_m;
    logic        busy,      busy_m;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    word_byte_serializer #(.NBYTES(7), .BYTE_W(8), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .byte_idx(byte_idx), .busy(busy)
    );

    word_byte_serializer #(.NBYTES(7), .BYTE_W(8), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready_m),
        .out_byte(out_byte_m), .out_valid(out_valid_m), .out_ready(out_ready),
        .out_last(out_last_m), .byte_idx(byte_idx_m), .busy(busy_m)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [7:0] pat [0:3];
    int beats;
    int c;

    initial begin
        pat[0] = 8'd1; pat[1] = 8'd0; pat[2] = 8'd0; pat[3] = 8'd1;
        rst = 1'b1; in_word = '0; in_valid = 1'b0; out_ready = 1'b0;
        cyc(); cyc();
        settle();
        chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_byte",  {56'd0, out_byte},  64'd0);
        chk("rst_byte_idx",  {61'd0, byte_idx},  64'd0);
        chk("rst_busy",      {63'd0, busy},      64'd0);
        chk("rst_out_last",  {63'd0, out_last},  64'd0);

        // Basic word, no backpressure; MSB-first instance sees the same word.
        rst = 1'b0; in_word = 56'h77_66_55_44_33_22_11; in_valid = 1'b1; out_ready = 1'b1;
        settle();
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
        chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
        cyc();
        in_valid = 1'b0; in_word = 56'hDEAD_BEEF_0000_00;
        for (int k = 0; k < 7; k++) begin
            settle();
            chk($sformatf("b1_valid_%0d", k),  {63'd0, out_valid}, 64'd1);
            chk($sformatf("b1_byte_%0d", k),   {56'd0, out_byte},  64'(8'h11 * (k + 1)));
            chk($sformatf("b1_idx_%0d", k),    {61'd0, byte_idx},  64'(k));
            chk($sformatf("b1_last_%0d", k),   {63'd0, out_last},  64'(k == 6));
            chk($sformatf("b1_rdy_%0d", k),    {63'd0, in_ready},  64'(k == 6));
            chk($sformatf("b1m_byte_%0d", k),  {56'd0, out_byte_m}, 64'(8'h77 - 8'h11 * k));
            chk($sformatf("b1m_last_%0d", k),  {63'd0, out_last_m}, 64'(k == 6));
            cyc();
        end
        settle();
        chk("b1_end_valid", {63'd0, out_valid}, 64'd0);
        chk("b1_end_busy",  {63'd0, busy},      64'd0);
        chk("b1_end_byte",  {56'd0, out_byte},  64'd0);
        chk("b1_end_idx",   {61'd0, byte_idx},  64'd0);
        chk("b1m_end_valid", {63'd0, out_valid_m}, 64'd0);

        // Backpressure: out_ready cycles 1,0,0,1.
        in_word = 56'h77_66_55_44_33_22_11; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        beats = 0;
        c = 0;
        while (beats < 7 && c < 40) begin
            out_ready = pat[c % 4][0];
            settle();
            chk($sformatf("bp_valid_%0d", c), {63'd0, out_valid}, 64'd1);
            chk($sformatf("bp_byte_%0d", c),  {56'd0, out_byte},  64'(8'h11 * (beats + 1)));
            chk($sformatf("bp_idx_%0d", c),   {61'd0, byte_idx},  64'(beats));
            chk($sformatf("bp_rdy_%0d", c),   {63'd0, in_ready},  64'(out_ready && beats == 6));
            if (out_ready) beats++;
            c++;
            cyc();
        end
        chk("bp_beats", 64'(beats), 64'd7);
        settle();
        chk("bp_end_valid", {63'd0, out_valid}, 64'd0);

        // Back-to-back words with in_valid held: B loads on A's last beat, no bubble.
        out_ready = 1'b1;
        in_word = 56'h06_05_04_03_02_01_00; in_valid = 1'b1;
        cyc();
        in_word = 56'hF6_F5_F4_F3_F2_F1_F0;
        for (int i = 0; i < 14; i++) begin
            settle();
            chk($sformatf("b2b_valid_%0d", i), {63'd0, out_valid}, 64'd1);
            chk($sformatf("b2b_byte_%0d", i),  {56'd0, out_byte},
                (i < 7) ? 64'(i) : 64'(8'hF0 + (i - 7)));
            if (i == 6) chk("b2b_load_rdy", {63'd0, in_ready}, 64'd1);
            cyc();
            if (i == 6) in_valid = 1'b0;
        end
        settle();
        chk("b2b_end_valid", {63'd0, out_valid}, 64'd0);

        // Reset after the 3rd beat discards the rest of the word.
        in_word = 56'h77_66_55_44_33_22_11; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc(); cyc(); cyc();
        settle();
        chk("mid_byte_before_rst", {56'd0, out_byte}, 64'h44);
        rst = 1'b1;
        settle();
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("mid_valid_%0d", i), {63'd0, out_valid}, 64'd0);
            chk($sformatf("mid_byte_%0d", i),  {56'd0, out_byte},  64'd0);
            cyc();
        end
        in_word = 56'hAA_99_88_CC_BB_5A_A5; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            logic [55:0] w;
            w = 56'hAA_99_88_CC_BB_5A_A5;
            settle();
            chk($sformatf("fresh_byte_%0d", k), {56'd0, out_byte}, 64'(w[k*8 +: 8]));
            chk($sformatf("fresh_idx_%0d", k),  {61'd0, byte_idx}, 64'(k));
            cyc();
        end

        // rst held with in_valid high: nothing loads until release; then stall in SHIFT.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; in_word = 56'h12_34_56_78_9A_BC_DE;
        settle();
        chk("hold_rst_rdy", {63'd0, in_ready}, 64'd0);
        cyc();
        settle();
        chk("hold_rst_busy",  {63'd0, busy},      64'd0);
        chk("hold_rst_valid", {63'd0, out_valid}, 64'd0);
        cyc();
        rst = 1'b0;
        settle();
        chk("rel_rdy", {63'd0, in_ready}, 64'd1);
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk($sformatf("rel_busy_%0d", i), {63'd0, busy},     64'd1);
            chk($sformatf("rel_byte_%0d", i), {56'd0, out_byte}, 64'hDE);
            chk($sformatf("rel_idx_%0d", i),  {61'd0, byte_idx}, 64'd0);
            chk($sformatf("rel_rdy_%0d", i),  {63'd0, in_ready}, 64'd0);
            cyc();
        end
        chk("rel_m_byte", {56'd0, out_byte_m}, 64'h12);
        out_ready = 1'b1;
        settle();
        chk("rel_b1_byte_pre", {56'd0, out_byte}, 64'hDE);
        cyc();
        settle();
        chk("rel_b2_byte", {56'd0, out_byte}, 64'hBC);
        chk("rel_b2_idx",  {61'd0, byte_idx}, 64'd1);
        for (int i = 0; i < 6; i++) cyc();
        settle();
        chk("rel_end_valid", {63'd0, out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
